// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, feeding a small valid/ready byte FIFO.
// Framing and overrun errors are reported through sticky flags cleared by err_clr.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t            state, state_nx;
    logic              rx_meta, rx_s;
    logic [DIV_W-1:0]  div_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;

    logic              div_clr;
    logic              bit_clr;
    logic              bit_take;
    logic              push;
    logic              frame_set;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop;
    logic              push_ok;
    logic              push_drop;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        div_clr   = 1'b0;
        bit_clr   = 1'b0;
        bit_take  = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    div_clr  = 1'b1;
                end
            end
            START: begin
                if (div_cnt == HALF_LAST) begin
                    div_clr = 1'b1;
                    bit_clr = 1'b1;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (div_cnt == DIV_LAST) begin
                    div_clr  = 1'b1;
                    bit_take = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (div_cnt == DIV_LAST) begin
                    div_clr = 1'b1;
                    if (rx_s) begin
                        push     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_nx  = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (div_clr) begin
                div_cnt <= '0;
            end else if (state == START || state == DATA || state == STOP) begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (bit_take) begin
                shift_reg[bit_cnt] <= rx_s;
                bit_cnt            <= bit_cnt + 3'd1;
            end
        end
    end

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && ((count != FULL_CNT) || pop);
    assign push_drop = push && !push_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                mem[wr_ptr] <= shift_reg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (push_drop) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign out_data   = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign fifo_count = count;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive stage that consumes the UART_TX line driven by mysoc_top. Used as the bench-side/peripheral receiver that turns the SoC's console output into bytes.
- Decodes 8N1 asynchronous serial (LSB first) using a per-bit clock-divider counter with mid-bit sampling.
- Buffers received bytes in a small FIFO with a valid/ready read port, and reports framing and overrun errors through sticky flags.

Parameters:
- CLK_DIV, 868, clk cycles per bit (100 MHz / 115200); legal range ≥ 4, even.
- FIFO_DEPTH, 4, byte entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, idle high; asynchronous to clk.
- out_data  out  8  byte at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun  out  1  sticky: byte completed while FIFO full.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- Reset values: out_valid=0, out_data=0, fifo_count=0, frame_err=0, overrun=0, state=IDLE, sync flops=1, bit counter=0, div counter=0.
- Synchroniser: rx passes through 2 flops (rx_s); every decision below uses rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s==0, go to START and clear div.
  - START: div counts 0..CLK_DIV/2-1. At terminal count, if rx_s==0 go to DATA (div=0, bit=0); otherwise treat as a glitch and return to IDLE. No flag is set.
  - DATA: div counts 0..CLK_DIV-1. At terminal count, shift rx_s into bit[bitcnt] (LSB first) and increment bitcnt. After bit 7, go to STOP.
  - STOP: at div terminal count, sample rx_s.
    - rx_s==1: push the byte and go to IDLE.
    - rx_s==0: set frame_err, drop the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from being decoded as 0x00 frames.
- Latency: the pushed byte appears on out_data/out_valid on the cycle after the stop-sample cycle.
- FIFO:
  - Circular buffer with wrapping read/write pointers; out_data is the head entry (registered array read).
  - Pop when out_valid && out_ready.
  - A push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrun=1; FIFO contents are unchanged.
  - Simultaneous push and pop: count unchanged and both pointers advance.
  - out_ready while empty is ignored.
- Sticky flags: err_clr clears them the next cycle. If a new error event coincides with err_clr, the error wins (flag reads 1).
- Reset mid-frame: asynchronous return to reset values; the partial byte and FIFO contents are discarded.
- Frame period: one frame is 10*CLK_DIV cycles nominal. A back-to-back start bit immediately after the stop sample is accepted, because IDLE reacts on the next cycle.

Test Plan:
1. CLK_DIV=16, send 0x55 then 0xA3 with out_ready=0.
   → fifo_count=2, out_valid=1, out_data=0x55.
   → Pulse out_ready for 1 cycle → out_data=0xA3, fifo_count=1.
   → No flags set.
2. CLK_DIV=16, drive rx low for 5 cycles then high.
   → START rejects the glitch; fifo_count stays 0; frame_err=0.
3. CLK_DIV=16, send 0x7E with the stop bit held low, then rx high.
   → frame_err=1, fifo_count=0, FSM in WAIT_HIGH until rx_s=1.
   → Then send 0x31 → out_data=0x31.
   → Pulse err_clr → frame_err=0.
4. FIFO_DEPTH=4, send 0x01..0x05 with out_ready=0.
   → fifo_count=4, overrun=1, head=0x01.
   → Drain all four → read order 0x01,0x02,0x03,0x04.
5. Full FIFO; complete a 6th byte 0x66 on the same cycle out_ready=1.
   → Push accepted, overrun unchanged, fifo_count stays 4, tail entry=0x66.
6. Assert reset mid-DATA after 4 bits of 0xF0 while 2 bytes are queued.
   → Immediately out_valid=0, fifo_count=0.
   → After release, a fresh 0x12 is received correctly.
